nes_rom_loader: RTL and testbench

NES_ROM_LOADER -- requirements
Module: nes_rom_loader

---
 rtl/nes_rom_loader.sv | 201 ++++++++++++++++++++
 tb/tb_nes_rom_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_rom_loader.sv
// rtl/nes_rom_loader.sv - copies a ROM image from DDR into the local buffer in 4 KB-safe bursts
module nes_rom_loader #(
    parameter int AM_DATA_WIDTH  = 8,
    parameter int AM_ADDR_WIDTH  = 32,
    parameter int AM_ID_WIDTH    = 4,
    parameter int MEM_ADDR_WIDTH = 15
) (
    input  logic                      i_axi_clk,
    input  logic                      i_axi_rst,
    input  logic                      i_start_stb,
    input  logic [AM_ADDR_WIDTH-1:0]  i_src_addr,
    input  logic [MEM_ADDR_WIDTH:0]   i_length,
    output logic                      o_busy,
    output logic                      o_done_stb,
    output logic                      o_error,
    output logic [MEM_ADDR_WIDTH:0]   o_count,
    output logic [AM_ID_WIDTH-1:0]    o_id,
    output logic [AM_ADDR_WIDTH-1:0]  o_addr,
    output logic [7:0]                o_data_len,
    output logic                      o_read_stb,
    input  logic                      i_ready,
    input  logic [AM_DATA_WIDTH-1:0]  i_r_tdata,
    input  logic                      i_r_tlast,
    input  logic                      i_r_tvalid,
    output logic                      o_r_tready,
    output logic                      o_lm_wen,
    output logic [MEM_ADDR_WIDTH-1:0] o_lm_addr,
    output logic [AM_DATA_WIDTH-1:0]  o_lm_din
);
    localparam int LW = MEM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [AM_ADDR_WIDTH-1:0]  src_q, src_d;
    logic [LW-1:0]             remain_q, remain_d;
    logic [8:0]                beats_left_q, beats_left_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic [LW-1:0]             count_q, count_d;
    logic [AM_ID_WIDTH-1:0]    id_q, id_d;
    logic [AM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]                data_len_q, data_len_d;
    logic                      read_stb_q, read_stb_d;
    logic                      lm_wen_q, lm_wen_d;
    logic [MEM_ADDR_WIDTH-1:0] lm_addr_q, lm_addr_d;
    logic [AM_DATA_WIDTH-1:0]  lm_din_q, lm_din_d;

    logic [8:0]  cap_len;
    logic [12:0] to_boundary;
    logic [8:0]  burst_beats;
    logic        length_zero;
    logic        length_oversize;
    logic        beat_accept;
    logic        final_beat;

    assign length_zero     = (i_length == '0);
    assign length_oversize = i_length[MEM_ADDR_WIDTH] && (i_length[MEM_ADDR_WIDTH-1:0] != '0);
    assign beat_accept     = i_r_tvalid && (state_q == ST_DATA);
    assign final_beat      = (beats_left_q == 9'd1);

    // Burst size: smallest of bytes left, 256 beats, and distance to the next 4 KB page
    always_comb begin
        cap_len     = (remain_q > LW'(256)) ? 9'd256 : remain_q[8:0];
        to_boundary = 13'd4096 - {1'b0, src_q[11:0]};
        burst_beats = (to_boundary < {4'd0, cap_len}) ? to_boundary[8:0] : cap_len;
    end

    // Next-state and datapath updates for the load sequencer
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        remain_d     = remain_q;
        beats_left_d = beats_left_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        count_d      = count_q;
        id_d         = id_q;
        addr_d       = addr_q;
        data_len_d   = data_len_q;
        read_stb_d   = 1'b0;
        lm_wen_d     = 1'b0;
        lm_addr_d    = lm_addr_q;
        lm_din_d     = lm_din_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start_stb) begin
                    src_d    = i_src_addr;
                    remain_d = i_length;
                    count_d  = '0;
                    error_d  = 1'b0;
                    id_d     = '0;
                    busy_d   = 1'b1;
                    if (length_zero) begin
                        state_d = ST_DONE;
                    end else if (length_oversize) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_ready) begin
                    addr_d       = src_q;
                    data_len_d   = 8'(burst_beats - 9'd1);
                    beats_left_d = burst_beats;
                    read_stb_d   = 1'b1;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_accept) begin
                    lm_wen_d     = 1'b1;
                    lm_din_d     = i_r_tdata;
                    lm_addr_d    = count_q[MEM_ADDR_WIDTH-1:0];
                    count_d      = count_q + LW'(1);
                    src_d        = src_q + AM_ADDR_WIDTH'(1);
                    remain_d     = remain_q - LW'(1);
                    beats_left_d = beats_left_q - 9'd1;
                    if (i_r_tlast != final_beat) begin
                        // Framing is broken: keep this beat, abandon the rest of the burst
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (final_beat) begin
                        id_d    = id_q + AM_ID_WIDTH'(1);
                        state_d = (remain_q == LW'(1)) ? ST_DONE : ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            remain_q     <= '0;
            beats_left_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            data_len_q   <= '0;
            read_stb_q   <= 1'b0;
            lm_wen_q     <= 1'b0;
            lm_addr_q    <= '0;
            lm_din_q     <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            remain_q     <= remain_d;
            beats_left_q <= beats_left_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            data_len_q   <= data_len_d;
            read_stb_q   <= read_stb_d;
            lm_wen_q     <= lm_wen_d;
            lm_addr_q    <= lm_addr_d;
            lm_din_q     <= lm_din_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done_stb = done_q;
    assign o_error    = error_q;
    assign o_count    = count_q;
    assign o_id       = id_q;
    assign o_addr     = addr_q;
    assign o_data_len = data_len_q;
    assign o_read_stb = read_stb_q;
    assign o_r_tready = (state_q == ST_DATA);
    assign o_lm_wen   = lm_wen_q;
    assign o_lm_addr  = lm_addr_q;
    assign o_lm_din   = lm_din_q;

endmodule

// File: tb/tb_nes_rom_loader.sv
// tb/tb_nes_rom_loader.sv - scoreboard bench for nes_rom_loader
module tb_nes_rom_loader;
    logic        clk;
    logic        rst_n;
    logic        start_stb;
    logic [31:0] src_addr;
    logic [15:0] length;
    logic        busy;
    logic        done_stb;
    logic        error;
    logic [15:0] count;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  data_len;
    logic        read_stb;
    logic        ready;
    logic [7:0]  r_tdata;
    logic        r_tlast;
    logic        r_tvalid;
    logic        r_tready;
    logic        lm_wen;
    logic [14:0] lm_addr;
    logic [7:0]  lm_din;

    nes_rom_loader dut (
        .i_axi_clk   (clk),
        .i_axi_rst   (rst_n),
        .i_start_stb (start_stb),
        .i_src_addr  (src_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done_stb  (done_stb),
        .o_error     (error),
        .o_count     (count),
        .o_id        (id),
        .o_addr      (addr),
        .o_data_len  (data_len),
        .o_read_stb  (read_stb),
        .i_ready     (ready),
        .i_r_tdata   (r_tdata),
        .i_r_tlast   (r_tlast),
        .i_r_tvalid  (r_tvalid),
        .o_r_tready  (r_tready),
        .o_lm_wen    (lm_wen),
        .o_lm_addr   (lm_addr),
        .o_lm_din    (lm_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } burst_t;
    typedef struct packed { logic [14:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic err; logic [15:0] cnt; } done_t;

    burst_t exp_burst[$];
    wr_t    exp_wr[$];
    done_t  exp_done[$];

    int n_cmp = 0;
    int n_fail = 0;
    int read_cnt = 0;
    int done_cnt = 0;
    int hold_ready = 0;
    int mismatch_at = -1;
    int load_beat = 0;
    int s_total;
    int s_idx;
    logic s_in_burst;
    logic s_acc;

    function automatic logic [7:0] beat_data(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a write or a done
    initial begin
        burst_t b;
        wr_t    w;
        done_t  d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (read_stb) begin
                    read_cnt++;
                    if (exp_burst.size() == 0) check("unexpected_read", 1, 0);
                    else begin
                        b = exp_burst.pop_front();
                        check("burst_addr", addr, b.addr);
                        check("burst_len", data_len, b.len);
                        check("burst_id", id, b.id);
                    end
                end
                if (lm_wen) begin
                    if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        check("write_addr", lm_addr, w.addr);
                        check("write_data", lm_din, w.data);
                    end
                end
                if (done_stb) begin
                    done_cnt++;
                    if (exp_done.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        d = exp_done.pop_front();
                        check("done_error", error, d.err);
                        check("done_count", count, d.cnt);
                        check("done_busy_low", busy, 0);
                    end
                end
            end
        end
    end

    // Read-channel slave: answers each o_read_stb with data_len+1 beats
    initial begin
        s_in_burst = 1'b0;
        s_acc = 1'b0;
        s_total = 0;
        s_idx = 0;
        r_tvalid = 1'b0;
        r_tlast = 1'b0;
        r_tdata = 8'h00;
        ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_in_burst = 1'b0;
                s_acc = 1'b0;
                r_tvalid = 1'b0;
                r_tlast = 1'b0;
                load_beat = 0;
                ready = (hold_ready == 0);
            end else begin
                if (s_acc) begin
                    if (load_beat == mismatch_at) s_in_burst = 1'b0;
                    s_idx++;
                    load_beat++;
                    if (s_idx == s_total) s_in_burst = 1'b0;
                end
                if (!s_in_burst && !busy) load_beat = 0;
                if (!s_in_burst && read_stb) begin
                    s_in_burst = 1'b1;
                    s_total = int'(data_len) + 1;
                    s_idx = 0;
                end
                if (s_in_burst) begin
                    r_tvalid = 1'b1;
                    r_tdata = beat_data(load_beat);
                    r_tlast = (s_idx == s_total - 1) ^ (load_beat == mismatch_at);
                end else begin
                    r_tvalid = 1'b0;
                    r_tlast = 1'b0;
                    r_tdata = 8'h00;
                end
                ready = !s_in_burst && (hold_ready == 0);
                s_acc = r_tvalid && r_tready;
            end
        end
    end

    task automatic push_burst(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i);
        exp_burst.push_back('{addr: a, len: l, id: i});
    endtask

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) exp_wr.push_back('{addr: 15'(i), data: beat_data(i)});
    endtask

    task automatic push_done(input logic e, input logic [15:0] c);
        exp_done.push_back('{err: e, cnt: c});
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] l);
        @(negedge clk);
        src_addr = a;
        length = l;
        start_stb = 1'b1;
        @(negedge clk);
        start_stb = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_in_time"}, (done_cnt != base), 1);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [127:0] all_outputs();
        return {busy, done_stb, error, count, id, addr, data_len, read_stb,
                r_tready, lm_wen, lm_addr, lm_din};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int n;
        rst_n = 1'b0;
        start_stb = 1'b0;
        src_addr = '0;
        length = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 16-byte burst
        push_burst(32'h1000_0000, 8'd15, 4'd0);
        push_writes(16);
        push_done(1'b0, 16'd16);
        do_start(32'h1000_0000, 16'd16);
        check("busy_after_start", busy, 1);
        wait_done("single", 200);

        // 600 bytes split into 256/256/88
        push_burst(32'h2000_0000, 8'd255, 4'd0);
        push_burst(32'h2000_0100, 8'd255, 4'd1);
        push_burst(32'h2000_0200, 8'd87, 4'd2);
        push_writes(600);
        push_done(1'b0, 16'd600);
        do_start(32'h2000_0000, 16'd600);
        wait_done("multi", 2000);

        // 4 KB page crossing
        push_burst(32'h0000_0FF0, 8'd15, 4'd0);
        push_burst(32'h0000_1000, 8'd15, 4'd1);
        push_writes(32);
        push_done(1'b0, 16'd32);
        do_start(32'h0000_0FF0, 16'd32);
        wait_done("boundary", 300);

        // Zero length
        r0 = read_cnt;
        push_done(1'b0, 16'd0);
        do_start(32'h7000_0000, 16'd0);
        wait_done("len0", 3);
        check("len0_no_read", read_cnt - r0, 0);

        // Oversize length
        r0 = read_cnt;
        push_done(1'b1, 16'd0);
        do_start(32'h7000_0000, 16'd32769);
        wait_done("oversize", 5);
        check("oversize_no_read", read_cnt - r0, 0);

        // tlast on beat 10 of 16
        mismatch_at = 9;
        push_burst(32'h3000_0000, 8'd15, 4'd0);
        push_writes(10);
        push_done(1'b1, 16'd10);
        do_start(32'h3000_0000, 16'd16);
        wait_done("tlast_mismatch", 200);
        mismatch_at = -1;
        check("error_sticky", error, 1);

        // i_ready held low for 50 cycles
        hold_ready = 1;
        repeat (2) @(negedge clk);
        r0 = read_cnt;
        push_burst(32'h4000_0000, 8'd15, 4'd0);
        push_writes(16);
        push_done(1'b0, 16'd16);
        do_start(32'h4000_0000, 16'd16);
        repeat (50) @(posedge clk);
        check("held_no_read", read_cnt - r0, 0);
        hold_ready = 0;
        wait_done("backpressure", 200);

        // Reset at beat 5, then a fresh load
        push_burst(32'h5000_0000, 8'd15, 4'd0);
        push_writes(16);
        push_done(1'b0, 16'd16);
        do_start(32'h5000_0000, 16'd16);
        n = 0;
        while (load_beat < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("reached_beat5", (load_beat >= 5), 1);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_load_outputs", all_outputs(), 0);
        repeat (3) @(negedge clk);
        exp_burst.delete();
        exp_wr.delete();
        exp_done.delete();
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", busy, 0);

        push_burst(32'h6000_0000, 8'd3, 4'd0);
        push_writes(4);
        push_done(1'b0, 16'd4);
        do_start(32'h6000_0000, 16'd4);
        wait_done("after_reset", 100);

        repeat (5) @(posedge clk);
        check("burst_queue_empty", exp_burst.size(), 0);
        check("write_queue_empty", exp_wr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
